// File: rtl/array_host_sequencer.sv
// Host-side sequencer for the array top: issues one instruction per command,
// holds start for a fixed execution window, then walks a PE x register range
// and streams every readback word out on a valid/ready interface.
module array_host_sequencer #(
  parameter int SIZE            = 4,
  parameter int MAX_WORD_LENGTH = 32,
  parameter int EXEC_CYCLES     = 2000,
  parameter int READ_LAT        = 2
) (
  input  logic            clk,
  input  logic            reset,
  // command side
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [31:0]     cmd_instr,
  input  logic [5:0]      cmd_length,
  input  logic [SIZE-1:0] cmd_pe_first,
  input  logic [SIZE:0]   cmd_pe_count,
  input  logic [9:0]      cmd_reg_base,
  input  logic [10:0]     cmd_reg_count,
  // array side
  output logic [31:0]     instruction,
  output logic            start,
  output logic [5:0]      LENGTH,
  output logic [SIZE-1:0] PE_Addr,
  output logic [9:0]      RegAddr,
  input  logic [15:0]     data,
  // result stream
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [15:0]     rd_data,
  output logic [SIZE-1:0] rd_pe,
  output logic [9:0]      rd_reg,
  output logic            rd_last,
  output logic            busy
);

  localparam logic [5:0]    MAX_LEN = 6'(MAX_WORD_LENGTH);
  localparam logic [15:0]   EXEC_LD = 16'(EXEC_CYCLES);
  localparam logic [15:0]   LAT_LD  = 16'(READ_LAT);
  localparam logic [SIZE:0] PE_ONE  = {{SIZE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, EXEC, SETTLE, PRESENT} state_t;

  state_t          state, state_nxt;
  logic [15:0]     cnt;
  logic [SIZE-1:0] pe_first_q;
  logic [SIZE:0]   pe_cnt_q, p_idx;
  logic [9:0]      reg_base_q;
  logic [10:0]     reg_cnt_q, r_idx;

  logic accept, cnt_done, empty, reg_end, last_word;

  assign accept    = (state == IDLE) && cmd_valid;
  assign cnt_done  = (cnt == 16'd1);
  assign empty     = (pe_cnt_q == '0) || (reg_cnt_q == '0);
  assign reg_end   = (r_idx == reg_cnt_q - 11'd1);
  assign last_word = reg_end && (p_idx == pe_cnt_q - PE_ONE);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = EXEC;
      EXEC:    if (cnt_done) state_nxt = empty ? IDLE : SETTLE;
      SETTLE:  if (cnt_done) state_nxt = PRESENT;
      PRESENT: if (rd_ready) state_nxt = rd_last ? IDLE : SETTLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Datapath: command latch, window counter, address walk and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      pe_first_q  <= '0;
      pe_cnt_q    <= '0;
      reg_base_q  <= '0;
      reg_cnt_q   <= '0;
      p_idx       <= '0;
      r_idx       <= '0;
      instruction <= '0;
      start       <= 1'b0;
      LENGTH      <= '0;
      PE_Addr     <= '0;
      RegAddr     <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_pe       <= '0;
      rd_reg      <= '0;
      rd_last     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pe_first_q  <= cmd_pe_first;
            pe_cnt_q    <= cmd_pe_count;
            reg_base_q  <= cmd_reg_base;
            reg_cnt_q   <= cmd_reg_count;
            instruction <= cmd_instr;
            LENGTH      <= (cmd_length > MAX_LEN) ? MAX_LEN : cmd_length;
            start       <= 1'b1;
            cnt         <= EXEC_LD;
          end
        end
        EXEC: begin
          if (cnt_done) begin
            start <= 1'b0;
            if (!empty) begin
              PE_Addr <= pe_first_q;
              RegAddr <= reg_base_q;
              p_idx   <= '0;
              r_idx   <= '0;
              cnt     <= LAT_LD;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        SETTLE: begin
          if (cnt_done) begin
            rd_data  <= data;
            rd_pe    <= PE_Addr;
            rd_reg   <= RegAddr;
            rd_last  <= last_word;
            rd_valid <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        PRESENT: begin
          // Dropping valid on the handshake edge guarantees no word is re-sent.
          if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (!rd_last) begin
              cnt <= LAT_LD;
              if (reg_end) begin
                r_idx   <= '0;
                p_idx   <= p_idx + PE_ONE;
                RegAddr <= reg_base_q;
                PE_Addr <= PE_Addr + PE_ONE[SIZE-1:0];
              end else begin
                r_idx   <= r_idx + 11'd1;
                RegAddr <= RegAddr + 10'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
